// File: rtl/sha256_transform_ctrl.sv
// Block sequencer for a looped SHA-256 transform: accepts padded blocks, chains the hash, returns the digest.
// Optional SHA-224 mode (IV select, truncated digest) is enabled by defining SHA256_CTRL_SHA224_EN.
module sha256_transform_ctrl #(
  parameter int LOOP   = 64,
  parameter int TF_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
`ifdef SHA256_CTRL_SHA224_EN
  input  logic         blk_sha224,
`endif
  output logic         tf_feedback,
  output logic [5:0]   tf_cnt,
  output logic [255:0] tf_state,
  output logic [511:0] tf_input,
  input  logic [255:0] tf_hash,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] digest,
  output logic         busy
);

  localparam logic [255:0] IV_256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [5:0] CNT_LAST = 6'(LOOP - 1);
  localparam logic [1:0] LAT_LAST = 2'(TF_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, WAIT, OUT} state_t;

  state_t       state;
  logic [255:0] chain;
  logic         msg_open;
  logic         last_q;
  logic [1:0]   lat_cnt;
  logic         new_msg;
  logic [255:0] iv_sel;
  logic [255:0] digest_sel;

  // A block starts from the IV when explicitly flagged or when no message is in flight.
  assign new_msg = blk_first | ~msg_open;

`ifdef SHA256_CTRL_SHA224_EN
  localparam logic [255:0] IV_224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };
  logic mode_224;

  assign iv_sel     = blk_sha224 ? IV_224 : IV_256;
  assign digest_sel = mode_224 ? {tf_hash[255:32], 32'h0} : tf_hash;
`else
  assign iv_sel     = IV_256;
  assign digest_sel = tf_hash;
`endif

  assign blk_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // NOTE: all state is assigned with <= so every register samples pre-edge values, never a neighbour's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the wide data registers are reset as well so the transform never sees X after reset.
      state       <= IDLE;
      chain       <= '0;
      msg_open    <= 1'b0;
      last_q      <= 1'b0;
      lat_cnt     <= '0;
      tf_feedback <= 1'b0;
      tf_cnt      <= '0;
      tf_state    <= '0;
      tf_input    <= '0;
      dig_valid   <= 1'b0;
      digest      <= '0;
`ifdef SHA256_CTRL_SHA224_EN
      mode_224    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (blk_valid) begin
            tf_input    <= blk_data;
            tf_state    <= new_msg ? iv_sel : chain;
            last_q      <= blk_last;
            msg_open    <= 1'b1;
            tf_cnt      <= '0;
            tf_feedback <= 1'b0;
            state       <= RUN;
`ifdef SHA256_CTRL_SHA224_EN
            if (new_msg) mode_224 <= blk_sha224;
`endif
          end
        end
        RUN: begin
          // From the second iteration on the transform feeds back its own working state.
          tf_feedback <= 1'b1;
          if (tf_cnt == CNT_LAST) begin
            tf_cnt  <= '0;
            lat_cnt <= '0;
            state   <= WAIT;
          end else begin
            tf_cnt <= tf_cnt + 6'd1;
          end
        end
        WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            chain       <= tf_hash;
            tf_feedback <= 1'b0;
            if (last_q) begin
              digest    <= digest_sel;
              dig_valid <= 1'b1;
              msg_open  <= 1'b0;
              state     <= OUT;
            end else begin
              state <= IDLE;
            end
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        OUT: begin
          if (dig_ready) begin
            dig_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
